// File: rtl/mem_lsu_align_if.sv
// ----------------------------------------------------------------------------
// mem_lsu_align_if
// Bundles the two buses of the load/store alignment unit.
//   Request side (pipeline <-> LSU):
//     req_valid, mem_read, mem_write, funct3, addr, wdata   pipeline -> LSU
//     req_ready, resp_valid, rdata, fault                   LSU -> pipeline
//   Memory side (LSU <-> data_mem, 64x32, async read, sync write):
//     dm_we, dm_A, dm_WD                                    LSU -> data_mem
//     dm_RD                                                 data_mem -> LSU
// The slave modport is the LSU itself. The master modport is its environment,
// which covers both the MEM-stage register and the data memory.
// ----------------------------------------------------------------------------
interface mem_lsu_align_if;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        dm_we;
  logic [31:0] dm_A;
  logic [31:0] dm_WD;
  logic [31:0] dm_RD;

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata, dm_RD,
    output req_ready, resp_valid, rdata, fault, dm_we, dm_A, dm_WD
  );

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wdata, dm_RD,
    input  req_ready, resp_valid, rdata, fault, dm_we, dm_A, dm_WD
  );
endinterface

// File: rtl/mem_lsu_align.sv
// ----------------------------------------------------------------------------
// mem_lsu_align
// Load/store alignment unit between the EX/MEM register and a word-wide data
// memory. It turns byte/half/word loads and stores into word accesses:
//   - Sub-word stores become read-modify-write cycles on a single word.
//   - Loads are sign-extended (B/H/W) or zero-extended (BU/HU).
//   - Accesses that cross a word boundary are split into two word accesses
//     over two cycles. req_ready stalls the pipeline during the first one.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          mem_lsu_align_if.slave, request side and data_mem side
// Parameters:
//   DEPTH_WORDS  data memory depth in words; the word index is addr[31:2]
//   MISALIGN_EN  1: split spanning accesses; 0: a spanning access faults
// ----------------------------------------------------------------------------
module mem_lsu_align #(
  parameter int DEPTH_WORDS = 64,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  mem_lsu_align_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] lo_q, lo_d;        // word0 captured during a split load

  logic [1:0]  off;
  logic [29:0] idx;
  logic        active, legal_f3, spanning, fault_c;
  logic [3:0]  bmask;
  logic [7:0]  wide_mask;         // byte lanes across word0 (low) and word1 (high)
  logic [63:0] wide_data;
  logic [63:0] ld_raw;
  logic [31:0] ld_word;

  assign off    = bus.addr[1:0];
  assign idx    = bus.addr[31:2];
  assign active = bus.req_valid && (bus.mem_read || bus.mem_write);

  // Legal loads: 000 001 010 100 101. Legal stores: 000 001 010.
  assign legal_f3 = bus.mem_write ? (!bus.funct3[2] && bus.funct3[1:0] != 2'b11)
                                  : (bus.funct3[1:0] != 2'b11 && !(bus.funct3[2] && bus.funct3[1]));

  assign spanning = (bus.funct3[1:0] == 2'b01 && off == 2'd3) ||
                    (bus.funct3[1:0] == 2'b10 && off != 2'd0);

  // Both words of a split access are range-checked before either is written.
  // The second word must not wrap past the end of memory.
  assign fault_c = (bus.mem_read && bus.mem_write) || !legal_f3 ||
                   (idx >= 30'(DEPTH_WORDS)) ||
                   (spanning && ((idx >= 30'(DEPTH_WORDS - 1)) || !MISALIGN_EN));

  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   bmask = 4'b0001;
      2'b01:   bmask = 4'b0011;
      default: bmask = 4'b1111;
    endcase
  end

  // Shift store data and lanes once into a 64-bit window. The low half goes to
  // word0 and the high half goes to word1, so both cycles share one datapath.
  assign wide_mask = {4'b0000, bmask} << off;
  assign wide_data = {32'h0, bus.wdata} << {off, 3'b000};

  // For a split load, the second cycle sees word1 on dm_RD and word0 in lo_q.
  assign ld_raw  = (state_q == SECOND) ? {bus.dm_RD, lo_q} : {32'h0, bus.dm_RD};
  assign ld_word = 32'(ld_raw >> {off, 3'b000});

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    bus.req_ready  = 1'b1;
    bus.resp_valid = 1'b0;
    bus.rdata      = 32'h0;
    bus.fault      = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_A       = 32'h0;
    bus.dm_WD      = 32'h0;
    state_d        = state_q;
    lo_d           = lo_q;

    if (state_q == SECOND) begin
      // Finish the split access even if req_valid has dropped.
      bus.dm_A       = {idx + 30'd1, 2'b00};
      bus.resp_valid = 1'b1;
      if (bus.mem_write) begin
        bus.dm_we = 1'b1;
        bus.dm_WD = merge_lanes(bus.dm_RD, wide_data[63:32], wide_mask[7:4]);
      end else begin
        bus.rdata = extend(bus.funct3, ld_word);
      end
      state_d = IDLE;
    end else if (active) begin
      if (fault_c) begin
        bus.resp_valid = 1'b1;
        bus.fault      = 1'b1;
      end else begin
        bus.dm_A = {idx, 2'b00};
        if (bus.mem_write) begin
          bus.dm_we = 1'b1;
          bus.dm_WD = merge_lanes(bus.dm_RD, wide_data[31:0], wide_mask[3:0]);
        end
        if (spanning) begin
          bus.req_ready = 1'b0;
          if (bus.mem_read)
            lo_d = bus.dm_RD;
          state_d = SECOND;
        end else begin
          bus.resp_valid = 1'b1;
          if (bus.mem_read)
            bus.rdata = extend(bus.funct3, ld_word);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu_align.sv
// ----------------------------------------------------------------------------
// tb_mem_lsu_align
// Testbench for mem_lsu_align. It contains:
//   - a behavioural 64x32 data memory (async read, sync write, backdoor load)
//   - a table of single-cycle vectors
//   - hand-written split-access and reset sequences
//   - randomized ops checked against a byte-addressed reference model
// ----------------------------------------------------------------------------
module tb_mem_lsu_align;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_lsu_align_if bus();

  mem_lsu_align #(.DEPTH_WORDS(DEPTH), .MISALIGN_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory with a backdoor write port for setup.
  logic [31:0] mem [DEPTH];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  assign bus.dm_RD = mem[bus.dm_A[7:2]];

  always @(posedge clk) begin
    if (bd_we)           mem[bd_idx]          <= bd_data;
    else if (bus.dm_we)  mem[bus.dm_A[7:2]]   <= bus.dm_WD;
  end

  // Reference model: memory viewed as a flat little-endian byte array.
  logic [7:0] ref_b [4*DEPTH];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = v;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
  endtask

  task automatic bd_write(input int i, input logic [31:0] d);
    bd_idx  = 6'(i);
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
    for (int k = 0; k < 4; k++) ref_b[4*i + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
  endfunction

  // {req_ready, resp_valid, fault, dm_we, rdata}
  function automatic logic [35:0] obs();
    return {bus.req_ready, bus.resp_valid, bus.fault, bus.dm_we, bus.rdata};
  endfunction

  // Executes one op against the DUT and checks it against the byte model.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int              n;
    logic            legal, flt, span, act;
    logic [63:0]     first, last;
    logic [31:0]     v;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    act   = rd || wr;
    first = {32'h0, a} >> 2;
    last  = ({32'h0, a} + 64'(n) - 64'd1) >> 2;
    flt   = act && ((rd && wr) || !legal || first >= 64'(DEPTH) || last >= 64'(DEPTH));
    span  = act && !flt && (first != last);
    v = 32'h0;
    if (act && rd && !flt) begin
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[int'(a) + k];
      case (f3)
        3'd0: v = {{24{v[7]}}, v[7:0]};
        3'd1: v = {{16{v[15]}}, v[15:0]};
        default: ;
      endcase
    end
    drive(1'b1, rd, wr, f3, a, wd);
    @(negedge clk);
    if (span) begin
      check("rand_split_c0", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, wr, 32'h0}));
      tick();
      @(negedge clk);
      check("rand_split_c1", 64'(obs()), 64'({1'b1, 1'b1, 1'b0, wr, v}));
    end else begin
      check("rand_op", 64'(obs()), 64'({1'b1, act, flt, act && !flt && wr, v}));
    end
    tick();
    if (act && wr && !flt)
      for (int k = 0; k < n; k++) ref_b[int'(a) + k] = wd[8*k +: 8];
  endtask

  typedef struct {
    logic        v, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        rdy, rv, flt, we;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Single-cycle vectors. Uses mem[2]=8899AABB and mem[3]=11223344.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h0B, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFF88};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h0B, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h00000088};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h0A, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF8899};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd5, 32'h08, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0000AABB};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h08, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h8899AABB};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h08, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFBB};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'd0, 32'h0D, 32'h000000EE, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd1, 32'h0E, 32'h5555BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h0C, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'hBEEFEE44};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'hFE, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 3'd2, 32'h100, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd3, 32'h00, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h08, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0};

    rst_n = 1'b0;
    bd_we = 1'b0;
    bd_idx = 6'd0;
    bd_data = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    check("reset_idle", 64'(obs()), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) bd_write(i, 32'h0);
    bd_write(2, 32'h8899AABB);
    bd_write(3, 32'h11223344);
    bd_write(4, 32'hDDCCBBAA);
    bd_write(5, 32'h44332211);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(obs()),
            64'({tbl[i].rdy, tbl[i].rv, tbl[i].flt, tbl[i].we, tbl[i].rdata}));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    check("sub_word_store_mem3", 64'(mem[3]), 64'h00000000BEEFEE44);

    // Split load across words 4 and 5
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h12, 32'h0);
    @(negedge clk);
    check("split_load_stall", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
    tick();
    @(negedge clk);
    check("split_load_data", 64'(obs()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 32'h2211DDCC}));
    tick();

    // Split store across words 6 and 7
    drive(1'b1, 1'b0, 1'b1, 3'd2, 32'h1B, 32'hA1B2C3D4);
    @(negedge clk);
    check("split_store_c0", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
    tick();
    @(negedge clk);
    check("split_store_c1", 64'(obs()), 64'({1'b1, 1'b1, 1'b0, 1'b1, 32'h0}));
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    check("split_store_mem6", 64'(mem[6]), 64'h00000000D4000000);
    check("split_store_mem7", 64'(mem[7]), 64'h0000000000A1B2C3);

    // Reset asserted while the split store is in its second cycle
    bd_write(6, 32'h0);
    bd_write(7, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 3'd2, 32'h1B, 32'hA1B2C3D4);
    @(negedge clk);
    check("rst_split_c0", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
    tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_split_idle", 64'(obs()), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    tick();
    rst_n = 1'b1;
    check("rst_split_mem6", 64'(mem[6]), 64'h00000000D4000000);
    check("rst_split_mem7", 64'(mem[7]), 64'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h18, 32'h0);
    @(negedge clk);
    check("rst_then_load", 64'(obs()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 32'hD4000000}));
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Randomized ops against the byte model
    for (int i = 0; i < DEPTH; i++) bd_write(i, $urandom);
    for (int i = 0; i < 400; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      rd  = (sel == 0) || (sel >= 2 && sel <= 5);
      wr  = (sel == 0) || (sel >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        sel = $urandom_range(0, 4);
        f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
      end
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
      run_op(rd, wr, f3, a, $urandom);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("final_mem%0d", i), 64'(mem[i]), 64'(ref_word(i)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
